mem_arbiter: RTL

Two-port arbiter sharing the processor's single program/data memory between the CPU controller (instruction fetch, load, store) and a program-loader port (debug or boot upload). It issues at most one memory access per cycle, with round-robin fairness between the ports. It also supports a bounded burst lock for the loader, and routes synchronous read data back to whichever port issued the read. It sits between the controller/datapath memory interface and the memory instance.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/rd_tag_pipe.sv | 35 +++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: port ownership, arbiter state and
// the read tag that travels alongside each memory read.
package mem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_e;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, owner: OWN_CPU};

    // Builds the tag pushed for an accepted access; writes never return data.
    function automatic rd_tag_t make_tag(input logic accepted, input logic we, input owner_e owner);
        rd_tag_t tag;
        tag.valid = accepted & ~we;
        tag.owner = owner;
        return tag;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register carrying read ownership tags so returning
// memory data can be steered to the port that issued the read.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    i_clr_n,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            rd_tag_t r_tag;
            if (gi == 0) begin : g_head
                // First stage captures the tag of this cycle's access.
                always_ff @(posedge clk) begin
                    if (!i_clr_n) r_tag <= RD_TAG_IDLE;
                    else          r_tag <= i_tag;
                end
            end else begin : g_body
                // Later stages shift the tag one cycle further.
                always_ff @(posedge clk) begin
                    if (!i_clr_n) r_tag <= RD_TAG_IDLE;
                    else          r_tag <= g_stage[gi-1].r_tag;
                end
            end
        end
    endgenerate

    assign o_tag = g_stage[DEPTH-1].r_tag;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous memory,
// with a bounded burst lock for the loader port and read-data routing.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              cpu_gnt,
    output logic              ldr_gnt,
    output logic              cpu_rvalid,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_active
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e        r_state, w_state_next;
    owner_e            r_last, w_last_next;
    logic [CNT_W-1:0]  r_lock_cnt, w_lock_cnt_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_cpu_gnt, w_ldr_gnt, w_any_gnt;
    owner_e            w_owner;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    rd_tag_t           w_push_tag, w_pipe_out;

    // Same-cycle grant: loader only while locked, otherwise round-robin on ties.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ldr_gnt = 1'b0;
        if (reset) begin
            if (r_state == LOCKED) begin
                w_ldr_gnt = ldr_req;
            end else if (cpu_req && ldr_req) begin
                if (r_last == OWN_LDR) w_cpu_gnt = 1'b1;
                else                   w_ldr_gnt = 1'b1;
            end else begin
                w_cpu_gnt = cpu_req;
                w_ldr_gnt = ldr_req;
            end
        end
    end

    assign w_any_gnt = w_cpu_gnt | w_ldr_gnt;
    assign w_owner   = w_ldr_gnt ? OWN_LDR : OWN_CPU;
    assign w_we      = w_ldr_gnt ? ldr_we    : cpu_we;
    assign w_addr    = w_ldr_gnt ? ldr_addr  : cpu_addr;
    assign w_wdata   = w_ldr_gnt ? ldr_wdata : cpu_wdata;

    // Lock FSM next state; a timeout hands the next tie to the CPU.
    always_comb begin
        w_state_next    = r_state;
        w_last_next     = r_last;
        w_lock_cnt_next = r_lock_cnt;
        if (w_any_gnt) w_last_next = w_owner;
        case (r_state)
            ARB: begin
                if (w_ldr_gnt && ldr_lock) begin
                    w_state_next    = LOCKED;
                    w_lock_cnt_next = CNT_W'(1);
                end
            end
            LOCKED: begin
                if (r_lock_cnt == CNT_W'(LOCK_MAX)) begin
                    w_state_next    = ARB;
                    w_last_next     = OWN_LDR;
                    w_lock_cnt_next = '0;
                end else if (!ldr_lock) begin
                    w_state_next    = ARB;
                    w_lock_cnt_next = '0;
                end else begin
                    w_lock_cnt_next = r_lock_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next    = ARB;
                w_lock_cnt_next = '0;
            end
        endcase
    end

    // State registers plus the held address/data seen by memory when idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ARB;
            r_last     <= OWN_LDR;
            r_lock_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_last     <= w_last_next;
            r_lock_cnt <= w_lock_cnt_next;
            if (w_any_gnt) begin
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
            end
        end
    end

    assign w_push_tag = make_tag(w_any_gnt, w_we, w_owner);

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .i_clr_n (reset),
        .i_tag   (w_push_tag),
        .o_tag   (w_pipe_out)
    );

    assign cpu_gnt     = w_cpu_gnt;
    assign ldr_gnt     = w_ldr_gnt;
    assign mem_en      = w_any_gnt;
    assign mem_we      = w_any_gnt & w_we;
    assign mem_addr    = w_any_gnt ? w_addr  : r_addr;
    assign mem_wdata   = w_any_gnt ? w_wdata : r_wdata;
    assign cpu_rvalid  = reset & w_pipe_out.valid & (w_pipe_out.owner == OWN_CPU);
    assign ldr_rvalid  = reset & w_pipe_out.valid & (w_pipe_out.owner == OWN_LDR);
    assign cpu_rdata   = mem_rdata;
    assign ldr_rdata   = mem_rdata;
    assign lock_active = (r_state == LOCKED);

endmodule
